// File: rtl/keypad_pkg.sv
// Shared types and key-map decode for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [2:0] CLS_DIGIT = 3'b000;
  localparam logic [2:0] CLS_STORE = 3'b001;
  localparam logic [2:0] CLS_PLUS  = 3'b010;
  localparam logic [2:0] CLS_MINUS = 3'b100;
  localparam logic [2:0] CLS_OTHER = 3'b111;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Row index r and column index c (column c is driven by col[c] low).
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = KEY_A;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = KEY_B;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'h0;
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] key_class(input logic [3:0] code);
    logic [2:0] cls;
    case (code)
      KEY_A:                   cls = CLS_STORE;
      KEY_B:                   cls = CLS_PLUS;
      KEY_C:                   cls = CLS_MINUS;
      KEY_D, KEY_STAR, KEY_HASH: cls = CLS_OTHER;
      default:                 cls = CLS_DIGIT;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up row lines.
module keypad_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating column drive, press/release debounce, key decode.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_pressed,
  output logic [2:0] is_sign_key,
  output state_e     dbg_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS);

  logic [3:0]    row_s;
  logic [CW-1:0] div_q, div_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    low_idx;
  logic [3:0]    key_value_q, key_value_d;
  logic [2:0]    cls_q, cls_d;
  logic          pressed_q, pressed_d;
  logic          tick;
  logic          row_bit;
  state_e        state_q, state_d;

  keypad_sync u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (row),
    .q     (row_s)
  );

  assign tick    = (div_q == DIV_LAST);
  assign div_d   = tick ? '0 : div_q + CW'(1);
  assign row_bit = row_s[row_idx_q];
  assign deb_inc = deb_q + DW'(1);

  // Lowest-index low row wins when several rows in the column are pressed.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    key_value_d = key_value_q;
    cls_d       = cls_q;
    pressed_d   = pressed_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (row_s == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = low_idx;
            deb_d     = DW'(1);
            state_d   = ST_DEBOUNCE;
            if (DEBOUNCE_TICKS <= 1) begin
              state_d     = ST_HELD;
              pressed_d   = 1'b1;
              key_value_d = key_code(low_idx, col_idx_q);
              cls_d       = key_class(key_code(low_idx, col_idx_q));
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!row_bit) begin
            deb_d = deb_inc;
            if (deb_inc >= DEB_LAST) begin
              state_d     = ST_HELD;
              pressed_d   = 1'b1;
              key_value_d = key_code(row_idx_q, col_idx_q);
              cls_d       = key_class(key_code(row_idx_q, col_idx_q));
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (row_bit) begin
            deb_d   = DW'(1);
            state_d = ST_RELEASE;
            if (DEBOUNCE_TICKS <= 1) begin
              state_d   = ST_SCAN;
              pressed_d = 1'b0;
              col_idx_d = col_idx_q + 2'd1;
            end
          end
        end
        default: begin
          // Release: any low tick aborts back to HELD without touching outputs.
          if (!row_bit) begin
            state_d = ST_HELD;
          end else begin
            deb_d = deb_inc;
            if (deb_inc >= DEB_LAST) begin
              state_d   = ST_SCAN;
              pressed_d = 1'b0;
              col_idx_d = col_idx_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SCAN;
      div_q       <= '0;
      deb_q       <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      key_value_q <= 4'h0;
      cls_q       <= CLS_OTHER;
      pressed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      deb_q       <= deb_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      key_value_q <= key_value_d;
      cls_q       <= cls_d;
      pressed_q   <= pressed_d;
    end
  end

  assign col         = ~(4'b0001 << col_idx_q);
  assign key_value   = key_value_q;
  assign key_pressed = pressed_q;
  assign is_sign_key = cls_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 keypad model on col/row.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_value;
  logic       key_pressed;
  logic [2:0] is_sign_key;
  state_e     dbg_state;
  logic [15:0] keys = '0;  // bit r*4+c = key at row r, column c held down

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .key_value   (key_value),
    .key_pressed (key_pressed),
    .is_sign_key (is_sign_key),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(keys[r*4 +: 4] & ~col);
    end
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  logic kp_prev  = 1'b0;

  always @(posedge clk) begin
    #2;
    if (key_pressed && !kp_prev) rise_cnt++;
    if (!key_pressed && kp_prev) fall_cnt++;
    kp_prev = key_pressed;
  end

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] val;
    logic [2:0] cls;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_kp(input logic lvl, input int bound, input string name, output int cyc);
    cyc = 0;
    while (key_pressed !== lvl && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(key_pressed), 32'(lvl));
  endtask

  task automatic press_only(input int idx);
    keys = 16'(1) << idx;
  endtask

  initial begin
    int   cyc;
    int   r0;
    int   f0;
    bit   dropped;
    bit   saw_release;
    logic [3:0] ec;

    vecs[0]  = '{2'd0, 2'd0, 4'h1, 3'b000};
    vecs[1]  = '{2'd0, 2'd1, 4'h2, 3'b000};
    vecs[2]  = '{2'd0, 2'd2, 4'h3, 3'b000};
    vecs[3]  = '{2'd0, 2'd3, 4'hA, 3'b001};
    vecs[4]  = '{2'd1, 2'd0, 4'h4, 3'b000};
    vecs[5]  = '{2'd1, 2'd1, 4'h5, 3'b000};
    vecs[6]  = '{2'd1, 2'd2, 4'h6, 3'b000};
    vecs[7]  = '{2'd1, 2'd3, 4'hB, 3'b010};
    vecs[8]  = '{2'd2, 2'd0, 4'h7, 3'b000};
    vecs[9]  = '{2'd2, 2'd1, 4'h8, 3'b000};
    vecs[10] = '{2'd2, 2'd2, 4'h9, 3'b000};
    vecs[11] = '{2'd2, 2'd3, 4'hC, 3'b100};
    vecs[12] = '{2'd3, 2'd0, 4'hE, 3'b111};
    vecs[13] = '{2'd3, 2'd1, 4'h0, 3'b000};
    vecs[14] = '{2'd3, 2'd2, 4'hF, 3'b111};
    vecs[15] = '{2'd3, 2'd3, 4'hD, 3'b111};

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h0000_000E);
    check("rst_kp", 32'(key_pressed), 32'd0);
    check("rst_val", 32'(key_value), 32'd0);
    check("rst_cls", 32'(is_sign_key), 32'd7);
    check("rst_state", 32'(dbg_state), 32'(ST_SCAN));

    // Column rotates once every SCAN_DIV clocks, starting at column 0
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("scan_hold", 32'(col), 32'h0000_000E);
    @(negedge clk);
    check("scan_step", 32'(col), 32'h0000_000D);

    // Every key: accept within 7 ticks plus sync, decode, freeze column, release
    for (int i = 0; i < 16; i++) begin
      r0 = rise_cnt;
      ec = ~(4'b0001 << vecs[i].c);
      press_only(int'(vecs[i].r) * 4 + int'(vecs[i].c));
      wait_kp(1'b1, 32, $sformatf("press_k%0d", i), cyc);
      check($sformatf("val_k%0d", i), 32'(key_value), 32'(vecs[i].val));
      check($sformatf("cls_k%0d", i), 32'(is_sign_key), 32'(vecs[i].cls));
      check($sformatf("colfrz_k%0d", i), 32'(col), 32'(ec));
      repeat (8) @(negedge clk);
      check($sformatf("onerise_k%0d", i), 32'(rise_cnt - r0), 32'd1);
      keys = '0;
      wait_kp(1'b0, 20, $sformatf("release_k%0d", i), cyc);
    end

    // Glitch: key 5 low for one tick in the column-1 slot
    cyc = 0;
    while (col == 4'b1101 && cyc < 20) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (col != 4'b1101 && cyc < 20) begin @(negedge clk); cyc++; end
    check("glitch_col1", 32'(col), 32'h0000_000D);
    r0 = rise_cnt;
    press_only(5);
    repeat (4) @(negedge clk);
    keys = '0;
    check("glitch_deb", 32'(dbg_state), 32'(ST_DEBOUNCE));
    check("glitch_frozen", 32'(col), 32'h0000_000D);
    cyc = 0;
    while (col == 4'b1101 && cyc < 20) begin @(negedge clk); cyc++; end
    check("glitch_resume", 32'(col), 32'h0000_000B);
    check("glitch_state", 32'(dbg_state), 32'(ST_SCAN));
    check("glitch_norise", 32'(rise_cnt - r0), 32'd0);

    // Press C, hold 20 ticks, release: one rise, falls on the 3rd high tick
    r0 = rise_cnt;
    press_only(11);
    wait_kp(1'b1, 32, "c_press", cyc);
    check("c_val", 32'(key_value), 32'h0000_000C);
    check("c_cls", 32'(is_sign_key), 32'h0000_0004);
    repeat (80) @(negedge clk);
    check("c_held", 32'(key_pressed), 32'd1);
    check("c_val_held", 32'(key_value), 32'h0000_000C);
    keys = '0;
    wait_kp(1'b0, 20, "c_release", cyc);
    check("c_rel_delay", 32'(cyc >= 11 && cyc <= 14), 32'd1);
    check("c_onerise", 32'(rise_cnt - r0), 32'd1);

    // Release bounce on key 9
    r0 = rise_cnt;
    press_only(10);
    wait_kp(1'b1, 32, "b_press", cyc);
    repeat (4) @(negedge clk);
    f0 = fall_cnt;
    dropped = 1'b0;
    saw_release = 1'b0;
    keys = '0;
    repeat (4) begin
      @(negedge clk);
      if (!key_pressed) dropped = 1'b1;
      if (dbg_state == ST_RELEASE) saw_release = 1'b1;
    end
    press_only(10);
    repeat (16) begin
      @(negedge clk);
      if (!key_pressed) dropped = 1'b1;
      if (dbg_state == ST_RELEASE) saw_release = 1'b1;
    end
    check("b_no_drop", 32'(dropped), 32'd0);
    check("b_saw_release", 32'(saw_release), 32'd1);
    check("b_back_held", 32'(dbg_state), 32'(ST_HELD));
    keys = '0;
    wait_kp(1'b0, 20, "b_release", cyc);
    check("b_onefall", 32'(fall_cnt - f0), 32'd1);
    check("b_onerise", 32'(rise_cnt - r0), 32'd1);

    // Keys 1 and 4 together, then key 2 during HELD
    r0 = rise_cnt;
    keys = 16'h0011;
    wait_kp(1'b1, 32, "m_press", cyc);
    check("m_val", 32'(key_value), 32'd1);
    check("m_cls", 32'(is_sign_key), 32'd0);
    keys = 16'h0013;
    repeat (24) @(negedge clk);
    check("m_val_keep", 32'(key_value), 32'd1);
    check("m_cls_keep", 32'(is_sign_key), 32'd0);
    check("m_col_keep", 32'(col), 32'h0000_000E);
    check("m_kp_keep", 32'(key_pressed), 32'd1);
    check("m_onerise", 32'(rise_cnt - r0), 32'd1);
    keys = '0;
    wait_kp(1'b0, 20, "m_release", cyc);

    // Reset while HELD with key A, then re-acceptance
    press_only(3);
    wait_kp(1'b1, 32, "a_press", cyc);
    check("a_cls", 32'(is_sign_key), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("a_rst_kp", 32'(key_pressed), 32'd0);
    check("a_rst_col", 32'(col), 32'h0000_000E);
    check("a_rst_val", 32'(key_value), 32'd0);
    check("a_rst_cls", 32'(is_sign_key), 32'd7);
    check("a_rst_state", 32'(dbg_state), 32'(ST_SCAN));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_kp(1'b1, 40, "a_repress", cyc);
    check("a_val2", 32'(key_value), 32'h0000_000A);
    check("a_cls2", 32'(is_sign_key), 32'd1);
    keys = '0;
    wait_kp(1'b0, 20, "a_release", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 27000, clk cycles per column slot (one scan tick).
REQ-002 Parameter DEBOUNCE_TICKS, default 10, consecutive scan ticks required to accept a press or a release.
REQ-003 Port clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 Port col  output  4  column drive, active-low one-hot; exactly one bit low at all times.
REQ-007 Port key_value  output  4  code of the accepted key.
REQ-008 Port key_pressed  output  1  level, high while the accepted key is held.
REQ-009 Port is_sign_key  output  3  key class for the number-storage stage.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer before any use; all row decisions SHALL use the synchronized value.
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap; a scan tick SHALL occur on each wrap.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-013 SCAN: on each tick with synced row == 4'hF, col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-014 SCAN: on a tick with any synced row bit low, the FSM SHALL latch the column index and the lowest-index low row, freeze col, and enter DEBOUNCE with the counter at 1.
REQ-015 DEBOUNCE: on each tick where the latched row bit is still low, the counter SHALL increment; on any tick where it is high, the FSM SHALL return to SCAN, and col SHALL resume rotating from the next column.
REQ-016 DEBOUNCE: when the counter reaches DEBOUNCE_TICKS, the FSM SHALL enter HELD, and key_value, is_sign_key and key_pressed=1 SHALL all update in the same clk edge.
REQ-017 HELD: key_pressed SHALL stay 1, with key_value and is_sign_key stable; col SHALL stay frozen; other rows going low SHALL be ignored.
REQ-018 HELD: on a tick with the latched row bit high, the FSM SHALL enter RELEASE with the counter at 1 and key_pressed still 1.
REQ-019 RELEASE: the latched row low on a tick SHALL return the FSM to HELD; DEBOUNCE_TICKS consecutive high ticks SHALL set key_pressed=0 and return to SCAN.
REQ-020 Key map (row, col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D.
REQ-021 key_value codes: digits = their value; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
REQ-022 is_sign_key: digits 3'b000; A (store operand) 3'b001; B (plus) 3'b010; C (minus) 3'b100; D, * and # 3'b111.
REQ-023 Exactly one key_pressed rising edge SHALL be produced per accepted press, regardless of hold duration.

Reset
REQ-024 On rst low, the block SHALL immediately set state=SCAN, col=4'b1110, key_value=0, key_pressed=0, is_sign_key=3'b111, and clear all counters and synchronizer flops.
REQ-025 Reset asserted in DEBOUNCE, HELD or RELEASE SHALL drop key_pressed at once, with no release debounce.
REQ-026 After rst deasserts, scanning SHALL start from column 0, and a key already held SHALL be re-detected and debounced normally.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state enum, the 3-bit is_sign_key class constants and the 4-bit special-key code constants.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module keypad_sync (4 bits wide, async active-low reset to all ones); the key-map decode SHALL be a function in keypad_pkg.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-029 Hold key 5 (r1, col1 low) stable -> key_pressed rises within 4+3 ticks (2-cycle sync included); key_value=5, is_sign_key=000; col frozen at 1101.
REQ-030 Glitch: row1 low for 1 tick during the col1 slot -> key_pressed never rises; col resumes rotation with 1011.
REQ-031 Press C, hold 20 ticks, release -> exactly one key_pressed rise; key_value=0xC, is_sign_key=100; key_pressed falls 3 ticks after release.
REQ-032 Release bounce: row high 1 tick, low, then high for 3 ticks -> key_pressed stays 1 through the bounce and falls once.
REQ-033 Keys 1 and 4 (same column) pressed together -> key_value=1; with key 2 pressed during HELD -> outputs unchanged.
REQ-034 rst pulsed low while HELD with key A -> key_pressed=0 and col=1110 asynchronously; after deassert, A is re-accepted with is_sign_key=001.
